// File: rtl/logic_cfg_seq.sv
// Serializes host configuration words LSB-first into the cell configuration chain and latches complete frames.
// Build macro LOGIC_CFG_SEQ_PARITY_EN adds CFG_PAR and rejects accepted words whose even parity does not match.
module logic_cfg_seq #(
    parameter int WORD_W      = 8,
    parameter int FRAME_WORDS = 4
) (
    input  logic              QCK,
    input  logic              QRT,
    input  logic [WORD_W-1:0] CFG_DATA,
    input  logic              CFG_VALID,
    input  logic              CFG_LAST,
`ifdef LOGIC_CFG_SEQ_PARITY_EN
    input  logic              CFG_PAR,
`endif
    output logic              CFG_READY,
    output logic              SCK_EN,
    output logic              SDO,
    output logic              CFG_LATCH,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    localparam int CNT_W = $clog2(FRAME_WORDS + 1);
    localparam int BIT_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_WORDS);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_LATCH = 3'd2,
        ST_FIN   = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t              state_r;
    logic [CNT_W-1:0]    word_cnt_r;
    logic [BIT_W-1:0]    bit_cnt_r;
    logic [WORD_W-1:0]   shreg_r;
    logic                last_r;
    logic                ready_r;
    logic                sck_en_r;
    logic                sdo_r;
    logic                latch_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;

    logic                accept_s;
    logic                full_s;
    logic                par_bad_s;

`ifdef LOGIC_CFG_SEQ_PARITY_EN
    function automatic logic even_par(input logic [WORD_W-1:0] d);
        return ^d;
    endfunction

    assign par_bad_s = (even_par(CFG_DATA) != CFG_PAR);
`else
    assign par_bad_s = 1'b0;
`endif

    assign accept_s = CFG_VALID & ready_r;
    assign full_s   = (word_cnt_r == CNT_FULL);

    // Sequencer FSM; all outputs are registered alongside the state they belong to.
    always_ff @(posedge QCK) begin
        if (QRT) begin
            state_r    <= ST_IDLE;
            word_cnt_r <= {CNT_W{1'b0}};
            bit_cnt_r  <= {BIT_W{1'b0}};
            shreg_r    <= {WORD_W{1'b0}};
            last_r     <= 1'b0;
            ready_r    <= 1'b1;
            sck_en_r   <= 1'b0;
            sdo_r      <= 1'b0;
            latch_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            latch_r <= 1'b0;
            done_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        word_cnt_r <= word_cnt_r + CNT_W'(1);
                        last_r     <= CFG_LAST;
                        ready_r    <= 1'b0;
                        busy_r     <= 1'b1;
                        if (par_bad_s) begin
                            state_r  <= ST_FAULT;
                            err_r    <= 1'b1;
                            sck_en_r <= 1'b0;
                            sdo_r    <= 1'b0;
                        end else begin
                            // Bit 0 goes out in the cycle right after acceptance.
                            state_r   <= ST_SHIFT;
                            sck_en_r  <= 1'b1;
                            sdo_r     <= CFG_DATA[0];
                            shreg_r   <= CFG_DATA >> 1;
                            bit_cnt_r <= BIT_W'(1);
                        end
                    end else begin
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (bit_cnt_r == BIT_LAST) begin
                        sck_en_r  <= 1'b0;
                        sdo_r     <= 1'b0;
                        bit_cnt_r <= {BIT_W{1'b0}};
                        shreg_r   <= {WORD_W{1'b0}};
                        if (last_r && full_s) begin
                            state_r <= ST_LATCH;
                            latch_r <= 1'b1;
                        end else if (!last_r && !full_s) begin
                            state_r <= ST_IDLE;
                            ready_r <= 1'b1;
                            busy_r  <= 1'b0;
                        end else begin
                            // Frame length and LAST marker disagree: never latch.
                            state_r <= ST_FAULT;
                            err_r   <= 1'b1;
                        end
                    end else begin
                        sdo_r     <= shreg_r[0];
                        shreg_r   <= shreg_r >> 1;
                        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                    end
                end
                ST_LATCH: begin
                    state_r <= ST_FIN;
                    done_r  <= 1'b1;
                end
                ST_FIN: begin
                    state_r    <= ST_IDLE;
                    word_cnt_r <= {CNT_W{1'b0}};
                    ready_r    <= 1'b1;
                    busy_r     <= 1'b0;
                end
                ST_FAULT: begin
                    ready_r  <= 1'b0;
                    busy_r   <= 1'b1;
                    err_r    <= 1'b1;
                    sck_en_r <= 1'b0;
                    sdo_r    <= 1'b0;
                end
                default: begin
                    state_r  <= ST_FAULT;
                    ready_r  <= 1'b0;
                    busy_r   <= 1'b1;
                    err_r    <= 1'b1;
                    sck_en_r <= 1'b0;
                    sdo_r    <= 1'b0;
                end
            endcase
        end
    end

    assign CFG_READY = ready_r;
    assign SCK_EN    = sck_en_r;
    assign SDO       = sdo_r;
    assign CFG_LATCH = latch_r;
    assign BUSY      = busy_r;
    assign DONE      = done_r;
    assign ERR       = err_r;

endmodule

// File: tb/tb_logic_cfg_seq.sv
// Bench for logic_cfg_seq: directed scenarios plus a random word stream checked against a frame-level model.
module tb_logic_cfg_seq;

    localparam int W  = 8;
    localparam int FW = 4;

    logic         QCK = 1'b0;
    logic         QRT = 1'b1;
    logic [W-1:0] CFG_DATA = 8'h00;
    logic         CFG_VALID = 1'b0;
    logic         CFG_LAST = 1'b0;
    logic         CFG_PAR = 1'b0;
    logic         CFG_READY, SCK_EN, SDO, CFG_LATCH, BUSY, DONE, ERR;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: words accepted in the current frame, and whether the block is stuck in a fault.
    int m_cnt     = 0;
    bit m_faulted = 1'b0;

    logic_cfg_seq #(.WORD_W(W), .FRAME_WORDS(FW)) dut (
        .QCK(QCK),
        .QRT(QRT),
        .CFG_DATA(CFG_DATA),
        .CFG_VALID(CFG_VALID),
        .CFG_LAST(CFG_LAST),
`ifdef LOGIC_CFG_SEQ_PARITY_EN
        .CFG_PAR(CFG_PAR),
`endif
        .CFG_READY(CFG_READY),
        .SCK_EN(SCK_EN),
        .SDO(SDO),
        .CFG_LATCH(CFG_LATCH),
        .BUSY(BUSY),
        .DONE(DONE),
        .ERR(ERR)
    );

    always #5 QCK = ~QCK;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, CFG_READY, 1'b1);
        chk({tag, "_busy"},  BUSY,      1'b0);
        chk({tag, "_sck"},   SCK_EN,    1'b0);
        chk({tag, "_sdo"},   SDO,       1'b0);
        chk({tag, "_latch"}, CFG_LATCH, 1'b0);
        chk({tag, "_done"},  DONE,      1'b0);
    endtask

    task automatic chk_fault(input string tag);
        chk({tag, "_err"},   ERR,       1'b1);
        chk({tag, "_ready"}, CFG_READY, 1'b0);
        chk({tag, "_busy"},  BUSY,      1'b1);
        chk({tag, "_sck"},   SCK_EN,    1'b0);
        chk({tag, "_latch"}, CFG_LATCH, 1'b0);
    endtask

    // Called at a falling edge; leaves QRT low and checks the post-reset outputs.
    task automatic do_reset();
        QRT = 1'b1;
        CFG_VALID = 1'b0;
        @(negedge QCK);
        QRT = 1'b0;
        chk_idle("rst");
        chk("rst_err", ERR, 1'b0);
        m_cnt = 0;
        m_faulted = 1'b0;
    endtask

    // Offer one word at a falling edge with the block idle; checks the shift and the frame outcome.
    task automatic send_word(input logic [W-1:0] d, input bit last, input bit hold, input bit par_bad);
        chk("offer_ready", CFG_READY, 1'b1);
        CFG_DATA  = d;
        CFG_LAST  = last;
        CFG_VALID = 1'b1;
        CFG_PAR   = (^d) ^ par_bad;
        @(negedge QCK);
        if (!hold) CFG_VALID = 1'b0;
        m_cnt++;
`ifdef LOGIC_CFG_SEQ_PARITY_EN
        if (par_bad) begin
            CFG_VALID = 1'b0;
            chk_fault("par");
            m_faulted = 1'b1;
            return;
        end
`endif
        for (int i = 0; i < W; i++) begin
            chk("shift_sck",   SCK_EN,    1'b1);
            chk("shift_sdo",   SDO,       d[i]);
            chk("shift_busy",  BUSY,      1'b1);
            chk("shift_ready", CFG_READY, 1'b0);
            chk("shift_latch", CFG_LATCH, 1'b0);
            @(negedge QCK);
        end
        CFG_VALID = 1'b0;
        if (!last && m_cnt < FW) begin
            chk_idle("next");
        end else if (last && m_cnt == FW) begin
            chk("latch_pulse", CFG_LATCH, 1'b1);
            chk("latch_sck",   SCK_EN,    1'b0);
            chk("latch_done",  DONE,      1'b0);
            chk("latch_err",   ERR,       1'b0);
            @(negedge QCK);
            chk("fin_done",  DONE,      1'b1);
            chk("fin_latch", CFG_LATCH, 1'b0);
            @(negedge QCK);
            chk_idle("after_fin");
            m_cnt = 0;
        end else begin
            chk_fault("frame_fault");
            m_faulted = 1'b1;
        end
    endtask

    // With the block faulted, further offers are ignored and the fault holds.
    task automatic fault_hold();
        CFG_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge QCK);
            chk_fault("hold");
        end
        CFG_VALID = 1'b0;
    endtask

    initial begin
        logic [W-1:0] frame_a [4];
        frame_a[0] = 8'hA5; frame_a[1] = 8'h3C; frame_a[2] = 8'hFF; frame_a[3] = 8'h01;

        @(negedge QCK);
        do_reset();

        // Good four-word frame.
        for (int k = 0; k < 4; k++) send_word(frame_a[k], k == 3, 1'b0, 1'b0);

        // LAST too early.
        send_word(8'h11, 1'b0, 1'b0, 1'b0);
        send_word(8'h22, 1'b1, 1'b0, 1'b0);
        fault_hold();
        do_reset();

        // LAST never asserted.
        for (int k = 0; k < 4; k++) send_word(frame_a[k], 1'b0, 1'b0, 1'b0);
        fault_hold();
        do_reset();

        // Reset after 5 bits of the third word, then a clean frame.
        send_word(8'h5A, 1'b0, 1'b0, 1'b0);
        send_word(8'hC3, 1'b0, 1'b0, 1'b0);
        CFG_DATA = 8'hF0; CFG_LAST = 1'b0; CFG_VALID = 1'b1; CFG_PAR = ^CFG_DATA;
        @(negedge QCK);
        CFG_VALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("mid_sdo", SDO, (8'hF0 >> i) & 8'h01);
            @(negedge QCK);
        end
        do_reset();
        for (int k = 0; k < 4; k++) send_word(frame_a[3 - k], k == 3, 1'b0, 1'b0);

        // Reset wins over a same-cycle acceptance.
        QRT = 1'b1; CFG_VALID = 1'b1; CFG_DATA = 8'hFF; CFG_LAST = 1'b0;
        @(negedge QCK);
        QRT = 1'b0; CFG_VALID = 1'b0;
        chk_idle("rst_prio");
        @(negedge QCK);
        chk_idle("rst_prio2");
        m_cnt = 0;

        // VALID held high through every shift.
        for (int k = 0; k < 4; k++) send_word(8'hA5, k == 3, 1'b1, 1'b0);

`ifdef LOGIC_CFG_SEQ_PARITY_EN
        send_word(8'h03, 1'b0, 1'b0, 1'b1);
        fault_hold();
        do_reset();
`endif

        // Random word stream; the model decides each outcome from count and LAST.
        for (int it = 0; it < 20; it++) begin
            int nw;
            nw = $urandom_range(1, FW);
            for (int w = 0; w < nw; w++) begin
                bit lst, hld, pb;
                lst = (w == nw - 1) && ($urandom_range(0, 3) != 0);
                hld = $urandom_range(0, 1) == 1;
                pb  = 1'b0;
`ifdef LOGIC_CFG_SEQ_PARITY_EN
                pb  = $urandom_range(0, 7) == 0;
`endif
                send_word(W'($urandom), lst, hld, pb);
                if (m_faulted) break;
            end
            if (m_faulted) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_cfg_seq.md
LOGIC_CFG_SEQ -- requirements
Module: logic_cfg_seq

Interface
REQ-001 The block SHALL have parameter WORD_W, default 8, giving the width of one configuration word in bits.
REQ-002 The block SHALL have parameter FRAME_WORDS, default 4, giving the number of words in one logic-cell configuration frame.
REQ-003 The block SHALL have port QCK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port QRT, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port CFG_DATA, input, WORD_W bits: configuration word from the host.
REQ-006 The block SHALL have port CFG_VALID, input, 1 bit: CFG_DATA and CFG_LAST are valid.
REQ-007 The block SHALL have port CFG_LAST, input, 1 bit: the current word is the final word of the frame.
REQ-008 The block SHALL have port CFG_READY, output, 1 bit: the block accepts a word in this cycle.
REQ-009 The block SHALL have port SCK_EN, output, 1 bit: shift enable to the cell configuration chain.
REQ-010 The block SHALL have port SDO, output, 1 bit: serial configuration data, valid when SCK_EN=1.
REQ-011 The block SHALL have port CFG_LATCH, output, 1 bit: one-cycle pulse that transfers the shifted frame into the cell configuration.
REQ-012 The block SHALL have port BUSY, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have port DONE, output, 1 bit: one-cycle frame-complete pulse.
REQ-014 The block SHALL have port ERR, output, 1 bit: sticky frame error flag.

Function
REQ-015 The FSM SHALL have the states IDLE, SHIFT, LATCH, FIN and FAULT.
REQ-016 CFG_READY SHALL equal 1 only in IDLE; a word is accepted in a cycle with CFG_VALID=1 and CFG_READY=1.
REQ-017 On acceptance, the block SHALL capture CFG_DATA and CFG_LAST, increment the word counter (width ceil(log2(FRAME_WORDS+1))), and enter SHIFT.
REQ-018 In SHIFT, the block SHALL drive SCK_EN=1 for exactly WORD_W consecutive cycles, with SDO carrying the captured word LSB first; the word accepted in cycle n SHALL have bit 0 on SDO in cycle n+1 and bit WORD_W-1 in cycle n+WORD_W.
REQ-019 After the last bit, with CFG_LAST clear and count < FRAME_WORDS, the FSM SHALL return to IDLE.
REQ-020 After the last bit, with CFG_LAST set and count == FRAME_WORDS, the FSM SHALL go to LATCH, assert CFG_LATCH for one cycle, then go to FIN.
REQ-021 In FIN, the block SHALL assert DONE for one cycle, clear the word counter, and return to IDLE.
REQ-022 After the last bit, with CFG_LAST set and count < FRAME_WORDS, or CFG_LAST clear and count == FRAME_WORDS, the FSM SHALL enter FAULT with no CFG_LATCH pulse.
REQ-023 In FAULT, ERR SHALL be 1, CFG_READY SHALL be 0, and only QRT SHALL exit to IDLE.
REQ-024 Outside SHIFT, SCK_EN SHALL be 0 and SDO SHALL be 0.
REQ-025 CFG_VALID while CFG_READY=0 SHALL be ignored, and a held word SHALL be consumed exactly once.
REQ-026 Minimum frame time SHALL be FRAME_WORDS*(WORD_W+1)+2 cycles.

Reset
REQ-027 While QRT=1 at a clock edge, the block SHALL enter IDLE from any state, including mid-SHIFT, and clear the word counter and shift register.
REQ-028 The cycle after reset, the outputs SHALL be SCK_EN=0, SDO=0, CFG_LATCH=0, BUSY=0, DONE=0, ERR=0 and CFG_READY=1; a partially shifted frame SHALL never be latched.
REQ-029 QRT SHALL take priority over an acceptance in the same cycle.

Configuration
REQ-030 With macro LOGIC_CFG_SEQ_PARITY_EN defined, the block SHALL add an input port CFG_PAR (1 bit, even parity over CFG_DATA); an accepted word with a parity mismatch SHALL send the FSM directly to FAULT without shifting.
REQ-031 Without LOGIC_CFG_SEQ_PARITY_EN defined, the CFG_PAR port and the parity check SHALL be absent.

Verification
REQ-032 Words 0xA5, 0x3C, 0xFF, 0x01 with LAST on the 4th -> 32 SCK_EN cycles; SDO begins 1,0,1,0,0,1,0,1; one CFG_LATCH pulse the cycle after the final bit, DONE the next cycle, ERR=0.
REQ-033 Words 0x11, 0x22 with LAST on the 2nd -> 16 shifts, then FAULT with ERR=1, no CFG_LATCH, and CFG_READY held at 0 until QRT.
REQ-034 Four words with LAST never asserted -> FAULT after the 32nd bit.
REQ-035 QRT pulse after 5 bits of the 3rd word -> the next cycle has SCK_EN=0, BUSY=0 and CFG_READY=1; a following full frame latches correctly.
REQ-036 CFG_VALID held high through a 0xA5 shift -> exactly 8 SCK_EN cycles per word and no duplicate acceptance.
REQ-037 (PARITY_EN) Word 0x03 with CFG_PAR=1 -> FAULT with ERR=1 and zero SCK_EN cycles.
